diff_drive_plant: RTL and testbench

- Cycle-based kinematic model of the differential-drive robot: the plant end of the wheel-command / position interface.
- Consumes 2-bit left/right wheel commands (forward 2'b01, back 2'b10, noMove 2'b00) from the navigation controller.
- Integrates heading and position once per motion tick and returns x/y coordinates to the controller and the VGA renderer.
- Sits between the navigation FSM and the display top.

---
 rtl/diff_drive_plant.sv | 190 +++++++++++++++++++
 tb/tb_diff_drive_plant.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/diff_drive_plant.sv
// Cycle-based kinematic model of a differential-drive robot: integrates heading and position per tick.
// Optional odometer accumulator is built only when DIFF_DRIVE_ODOM_EN is defined.
module diff_drive_plant #(
  parameter int unsigned INIT_X    = 400000000,
  parameter int unsigned INIT_Y    = 400000000,
  parameter int unsigned X_MAX     = 800000000,
  parameter int unsigned Y_MAX     = 800000000,
  parameter int unsigned STEP      = 4,
  parameter int unsigned DIAG_STEP = 3,
  parameter int unsigned ROT_TICKS = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        tick_i,
  input  logic [1:0]  left_i,
  input  logic [1:0]  right_i,
  output logic [31:0] x_c_o,
  output logic [31:0] y_c_o,
  output logic [2:0]  heading_o,
  output logic [1:0]  state_o,
  output logic        bump_o,
  output logic        cmd_err_o,
  output logic [31:0] odom_o
);

  typedef enum logic [1:0] {StIdle = 2'b00, StMoving = 2'b01, StRotating = 2'b10} state_e;

  localparam int unsigned CntW = $clog2(ROT_TICKS + 1);
  localparam logic [CntW-1:0] RotLast = CntW'(ROT_TICKS);

  // Axis direction codes: 01 = increase, 10 = decrease, 00 = no change.
  localparam logic [1:0] DirNone = 2'b00;
  localparam logic [1:0] DirPlus = 2'b01;
  localparam logic [1:0] DirMinus = 2'b10;

  localparam logic [1:0] CmdFwd = 2'b01;
  localparam logic [1:0] CmdBack = 2'b10;
  localparam logic [1:0] CmdNone = 2'b00;
  localparam logic [1:0] CmdBad = 2'b11;

  logic [31:0]     x_q, x_d, y_q, y_d;
  logic [2:0]      heading_q, heading_d;
  state_e          state_q, state_d;
  logic            bump_q, bump_d;
  logic            cmd_err_q, cmd_err_d;
  logic [CntW-1:0] rot_cnt_q, rot_cnt_d;
  logic            rot_ccw_q, rot_ccw_d;

  logic [1:0]      dx_dir, dy_dir;
  logic [31:0]     mag;
  logic [31:0]     x_mv, y_mv;
  logic            x_clip, y_clip;
  logic            move_en;
  logic [CntW-1:0] cnt_base, cnt_inc;

  // 33-bit intermediate so the upper-bound test sees any carry out of 32 bits.
  function automatic logic [32:0] axis_step(input logic [31:0] pos, input logic [1:0] dir,
                                            input logic [31:0] step, input logic [31:0] lim);
    logic [32:0] sum;
    logic [32:0] res;
    res = {1'b0, pos};
    unique case (dir)
      DirPlus: begin
        sum = {1'b0, pos} + {1'b0, step};
        res = (sum > {1'b0, lim}) ? {1'b1, lim} : {1'b0, sum[31:0]};
      end
      DirMinus: begin
        res = (pos < step) ? 33'h1_0000_0000 : {1'b0, pos - step};
      end
      default: res = {1'b0, pos};
    endcase
    return res;  // bit 32 flags a clamp
  endfunction

  always_comb begin
    dx_dir = DirNone;
    dy_dir = DirNone;
    unique case (heading_q)
      3'd0: begin dx_dir = DirPlus;  dy_dir = DirNone;  end
      3'd1: begin dx_dir = DirPlus;  dy_dir = DirPlus;  end
      3'd2: begin dx_dir = DirNone;  dy_dir = DirPlus;  end
      3'd3: begin dx_dir = DirMinus; dy_dir = DirPlus;  end
      3'd4: begin dx_dir = DirMinus; dy_dir = DirNone;  end
      3'd5: begin dx_dir = DirMinus; dy_dir = DirMinus; end
      3'd6: begin dx_dir = DirNone;  dy_dir = DirMinus; end
      default: begin dx_dir = DirPlus; dy_dir = DirMinus; end
    endcase
    // Reversing swaps plus and minus.
    if (left_i == CmdBack) begin
      dx_dir = {dx_dir[0], dx_dir[1]};
      dy_dir = {dy_dir[0], dy_dir[1]};
    end
  end

  assign mag = heading_q[0] ? 32'(DIAG_STEP) : 32'(STEP);
  assign {x_clip, x_mv} = axis_step(x_q, dx_dir, mag, 32'(X_MAX));
  assign {y_clip, y_mv} = axis_step(y_q, dy_dir, mag, 32'(Y_MAX));

  assign move_en = tick_i && (left_i == right_i) && (left_i == CmdFwd || left_i == CmdBack);

  // A reversal of rotation direction discards the partial count.
  assign cnt_base = (rot_ccw_q != (left_i == CmdNone)) ? '0 : rot_cnt_q;
  assign cnt_inc  = cnt_base + CntW'(1);

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    heading_d = heading_q;
    state_d   = state_q;
    bump_d    = 1'b0;
    cmd_err_d = cmd_err_q;
    rot_cnt_d = rot_cnt_q;
    rot_ccw_d = rot_ccw_q;
    if (tick_i) begin
      state_d   = StIdle;
      rot_cnt_d = '0;
      if (left_i == CmdBad || right_i == CmdBad) begin
        cmd_err_d = 1'b1;
      end else if (move_en) begin
        state_d = StMoving;
        x_d     = x_mv;
        y_d     = y_mv;
        bump_d  = x_clip | y_clip;
      end else if ((left_i == CmdNone && right_i == CmdFwd) ||
                   (left_i == CmdFwd && right_i == CmdNone)) begin
        state_d   = StRotating;
        rot_ccw_d = (left_i == CmdNone);
        if (cnt_inc == RotLast) begin
          rot_cnt_d = '0;
          heading_d = rot_ccw_d ? heading_q + 3'd1 : heading_q - 3'd1;
        end else begin
          rot_cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q       <= 32'(INIT_X);
      y_q       <= 32'(INIT_Y);
      heading_q <= 3'd0;
      state_q   <= StIdle;
      bump_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      rot_cnt_q <= '0;
      rot_ccw_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      heading_q <= heading_d;
      state_q   <= state_d;
      bump_q    <= bump_d;
      cmd_err_q <= cmd_err_d;
      rot_cnt_q <= rot_cnt_d;
      rot_ccw_q <= rot_ccw_d;
    end
  end

`ifdef DIFF_DRIVE_ODOM_EN
  logic [31:0] odom_q, odom_d;
  logic [31:0] dx_abs, dy_abs;

  always_comb begin
    dx_abs = (x_mv >= x_q) ? x_mv - x_q : x_q - x_mv;
    dy_abs = (y_mv >= y_q) ? y_mv - y_q : y_q - y_mv;
    odom_d = odom_q;
    if (move_en && !(left_i == CmdBad || right_i == CmdBad)) begin
      odom_d = odom_q + dx_abs + dy_abs;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) odom_q <= '0;
    else         odom_q <= odom_d;
  end

  assign odom_o = odom_q;
`else
  assign odom_o = '0;
`endif

  assign x_c_o     = x_q;
  assign y_c_o     = y_q;
  assign heading_o = heading_q;
  assign state_o   = state_q;
  assign bump_o    = bump_q;
  assign cmd_err_o = cmd_err_q;

endmodule

// File: tb/tb_diff_drive_plant.sv
// Directed self-checking bench for diff_drive_plant; a second instance with tight x bounds
// exercises clamping.
module tb_diff_drive_plant;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [1:0]  left = 2'b00;
  logic [1:0]  right = 2'b00;

  logic [31:0] x_a, y_a, odom_a, x_b, y_b, odom_b;
  logic [2:0]  hd_a, hd_b;
  logic [1:0]  st_a, st_b;
  logic        bump_a, bump_b, err_a, err_b;

  int n_vec = 0;
  int n_err = 0;

`ifdef DIFF_DRIVE_ODOM_EN
  localparam int unsigned OdomMainExp = 14;
  localparam int unsigned OdomClipExp = 16;
`else
  localparam int unsigned OdomMainExp = 0;
  localparam int unsigned OdomClipExp = 0;
`endif

  always #5 clk = ~clk;

  diff_drive_plant u_dut (
    .clk_i(clk), .reset_i(reset), .tick_i(tick), .left_i(left), .right_i(right),
    .x_c_o(x_a), .y_c_o(y_a), .heading_o(hd_a), .state_o(st_a), .bump_o(bump_a),
    .cmd_err_o(err_a), .odom_o(odom_a)
  );

  diff_drive_plant #(.INIT_X(6), .X_MAX(10)) u_clip (
    .clk_i(clk), .reset_i(reset), .tick_i(tick), .left_i(left), .right_i(right),
    .x_c_o(x_b), .y_c_o(y_b), .heading_o(hd_b), .state_o(st_b), .bump_o(bump_b),
    .cmd_err_o(err_b), .odom_o(odom_b)
  );

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick_cmd(input logic [1:0] l, input logic [1:0] r);
    @(negedge clk);
    tick = 1'b1; left = l; right = r;
    @(negedge clk);
    tick = 1'b0; left = 2'b00; right = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (x_a !== 32'd400000000) begin n_err++; $display("FAIL rst_x: got %0d want 400000000", x_a); end
    n_vec++; if (y_a !== 32'd400000000) begin n_err++; $display("FAIL rst_y: got %0d want 400000000", y_a); end
    n_vec++; if (hd_a !== 3'd0) begin n_err++; $display("FAIL rst_heading: got %0d want 0", hd_a); end
    n_vec++; if (st_a !== 2'b00) begin n_err++; $display("FAIL rst_state: got %0d want 0", st_a); end
    n_vec++; if ({bump_a, err_a} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {bump_a, err_a}); end
    n_vec++; if (odom_a !== 32'd0) begin n_err++; $display("FAIL rst_odom: got %0d want 0", odom_a); end
    // Reset wins over a simultaneous tick.
    @(negedge clk);
    reset = 1'b1; tick = 1'b1; left = 2'b01; right = 2'b01;
    @(negedge clk);
    reset = 1'b0; tick = 1'b0; left = 2'b00; right = 2'b00;
    n_vec++; if (x_a !== 32'd400000000 || st_a !== 2'b00) begin
      n_err++; $display("FAIL rst_over_tick: got x=%0d st=%0d want 400000000/0", x_a, st_a);
    end
  endtask

  task automatic test_forward();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick_cmd(2'b01, 2'b01);
      n_vec++; if (x_a !== 32'd400000000 + 32'(4 * i)) begin
        n_err++; $display("FAIL fwd_x%0d: got %0d want %0d", i, x_a, 400000000 + 4 * i);
      end
    end
    n_vec++; if (y_a !== 32'd400000000) begin n_err++; $display("FAIL fwd_y: got %0d want 400000000", y_a); end
    n_vec++; if (st_a !== 2'b01) begin n_err++; $display("FAIL fwd_state: got %0d want 1", st_a); end
    n_vec++; if (hd_a !== 3'd0) begin n_err++; $display("FAIL fwd_heading: got %0d want 0", hd_a); end
    repeat (3) @(negedge clk);
    n_vec++; if (st_a !== 2'b01 || x_a !== 32'd400000012 || bump_a !== 1'b0) begin
      n_err++; $display("FAIL hold: got st=%0d x=%0d bump=%b want 1/400000012/0", st_a, x_a, bump_a);
    end
  endtask

  task automatic test_rotate();
    for (int i = 1; i <= 4; i++) begin
      tick_cmd(2'b00, 2'b01);
      n_vec++; if (hd_a !== ((i == 4) ? 3'd1 : 3'd0) || st_a !== 2'b10) begin
        n_err++; $display("FAIL rot_ccw%0d: got hd=%0d st=%0d want %0d/2", i, hd_a, st_a, (i == 4) ? 1 : 0);
      end
    end
    tick_cmd(2'b01, 2'b01);
    n_vec++; if (x_a !== 32'd400000015 || y_a !== 32'd400000003) begin
      n_err++; $display("FAIL diag_fwd: got %0d,%0d want 400000015,400000003", x_a, y_a);
    end
  endtask

  task automatic test_partial_rotation();
    do_reset();
    repeat (3) tick_cmd(2'b00, 2'b01);
    tick_cmd(2'b00, 2'b00);
    n_vec++; if (st_a !== 2'b00 || hd_a !== 3'd0) begin
      n_err++; $display("FAIL idle_break: got st=%0d hd=%0d want 0/0", st_a, hd_a);
    end
    repeat (3) tick_cmd(2'b00, 2'b01);
    n_vec++; if (hd_a !== 3'd0) begin n_err++; $display("FAIL partial_3: got %0d want 0", hd_a); end
    tick_cmd(2'b00, 2'b01);
    n_vec++; if (hd_a !== 3'd1) begin n_err++; $display("FAIL partial_4: got %0d want 1", hd_a); end

    do_reset();
    repeat (2) tick_cmd(2'b00, 2'b01);
    repeat (3) tick_cmd(2'b01, 2'b00);
    n_vec++; if (hd_a !== 3'd0) begin n_err++; $display("FAIL dirchg_3: got %0d want 0", hd_a); end
    tick_cmd(2'b01, 2'b00);
    n_vec++; if (hd_a !== 3'd7 || st_a !== 2'b10) begin
      n_err++; $display("FAIL dirchg_4: got hd=%0d st=%0d want 7/2", hd_a, st_a);
    end
    tick_cmd(2'b01, 2'b01);
    n_vec++; if (x_a !== 32'd400000003 || y_a !== 32'd399999997) begin
      n_err++; $display("FAIL diag7_fwd: got %0d,%0d want 400000003,399999997", x_a, y_a);
    end
    tick_cmd(2'b10, 2'b10);
    n_vec++; if (x_a !== 32'd400000000 || y_a !== 32'd400000000 || st_a !== 2'b01) begin
      n_err++; $display("FAIL diag7_back: got %0d,%0d st=%0d want 400000000,400000000/1", x_a, y_a, st_a);
    end
    // back+forward is a legal idle command and must clear partial progress.
    repeat (3) tick_cmd(2'b01, 2'b00);
    tick_cmd(2'b10, 2'b01);
    n_vec++; if (st_a !== 2'b00) begin n_err++; $display("FAIL mixed_idle: got %0d want 0", st_a); end
    tick_cmd(2'b01, 2'b00);
    n_vec++; if (hd_a !== 3'd7) begin n_err++; $display("FAIL mixed_clear: got %0d want 7", hd_a); end
  endtask

  task automatic test_clamp();
    do_reset();
    tick_cmd(2'b10, 2'b10);
    n_vec++; if (x_b !== 32'd2 || bump_b !== 1'b0) begin
      n_err++; $display("FAIL clip_back1: got x=%0d bump=%b want 2/0", x_b, bump_b);
    end
    tick_cmd(2'b10, 2'b10);
    n_vec++; if (x_b !== 32'd0 || bump_b !== 1'b1) begin
      n_err++; $display("FAIL clip_back2: got x=%0d bump=%b want 0/1", x_b, bump_b);
    end
    @(negedge clk);
    n_vec++; if (bump_b !== 1'b0) begin n_err++; $display("FAIL bump_pulse: got %b want 0", bump_b); end
    tick_cmd(2'b10, 2'b10);
    n_vec++; if (x_b !== 32'd0 || bump_b !== 1'b1 || st_b !== 2'b01) begin
      n_err++; $display("FAIL clip_back3: got x=%0d bump=%b st=%0d want 0/1/1", x_b, bump_b, st_b);
    end
    tick_cmd(2'b01, 2'b01);
    tick_cmd(2'b01, 2'b01);
    n_vec++; if (x_b !== 32'd8 || bump_b !== 1'b0) begin
      n_err++; $display("FAIL clip_fwd2: got x=%0d bump=%b want 8/0", x_b, bump_b);
    end
    tick_cmd(2'b01, 2'b01);
    n_vec++; if (x_b !== 32'd10 || bump_b !== 1'b1 || y_b !== 32'd400000000) begin
      n_err++; $display("FAIL clip_upper: got x=%0d bump=%b y=%0d want 10/1/400000000", x_b, bump_b, y_b);
    end
    n_vec++; if (odom_b !== OdomClipExp) begin
      n_err++; $display("FAIL clip_odom: got %0d want %0d", odom_b, OdomClipExp);
    end
  endtask

  task automatic test_cmd_err();
    do_reset();
    tick_cmd(2'b11, 2'b01);
    n_vec++; if (st_a !== 2'b00 || x_a !== 32'd400000000 || err_a !== 1'b1) begin
      n_err++; $display("FAIL bad_left: got st=%0d x=%0d err=%b want 0/400000000/1", st_a, x_a, err_a);
    end
    tick_cmd(2'b01, 2'b01);
    n_vec++; if (x_a !== 32'd400000004 || err_a !== 1'b1) begin
      n_err++; $display("FAIL err_sticky: got x=%0d err=%b want 400000004/1", x_a, err_a);
    end
    tick_cmd(2'b01, 2'b11);
    n_vec++; if (st_a !== 2'b00 || x_a !== 32'd400000004) begin
      n_err++; $display("FAIL bad_right: got st=%0d x=%0d want 0/400000004", st_a, x_a);
    end
    do_reset();
    n_vec++; if (err_a !== 1'b0 || x_a !== 32'd400000000) begin
      n_err++; $display("FAIL err_clear: got err=%b x=%0d want 0/400000000", err_a, x_a);
    end
  endtask

  task automatic test_odom();
    do_reset();
    repeat (2) tick_cmd(2'b01, 2'b01);
    repeat (4) tick_cmd(2'b00, 2'b01);
    tick_cmd(2'b01, 2'b01);
    n_vec++; if (x_a !== 32'd400000011 || y_a !== 32'd400000003) begin
      n_err++; $display("FAIL odom_pos: got %0d,%0d want 400000011,400000003", x_a, y_a);
    end
    n_vec++; if (odom_a !== OdomMainExp) begin
      n_err++; $display("FAIL odom: got %0d want %0d", odom_a, OdomMainExp);
    end
  endtask

  task automatic test_reset_mid_rotation();
    do_reset();
    repeat (2) tick_cmd(2'b00, 2'b01);
    do_reset();
    n_vec++; if (hd_a !== 3'd0 || st_a !== 2'b00) begin
      n_err++; $display("FAIL midrot_rst: got hd=%0d st=%0d want 0/0", hd_a, st_a);
    end
    repeat (3) tick_cmd(2'b00, 2'b01);
    n_vec++; if (hd_a !== 3'd0) begin n_err++; $display("FAIL midrot_3: got %0d want 0", hd_a); end
    tick_cmd(2'b00, 2'b01);
    n_vec++; if (hd_a !== 3'd1) begin n_err++; $display("FAIL midrot_4: got %0d want 1", hd_a); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_rotate();
    test_partial_rotation();
    test_clamp();
    test_cmd_err();
    test_odom();
    test_reset_mid_rotation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
